// File: rtl/clk_div_prog.sv
// Programmable glitch-free clock divider: factor changes are applied only
// after the output has been gated off at the end of a low phase.

module clk_mux_cell (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);
  assign clk_o = sel_i ? clk1_i : clk0_i;
endmodule

module clk_gate_cell (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic r_en_lat;

  // Enable is captured only while the clock is low, so it cannot truncate a high phase.
  always_latch begin
    if (!clk_i) r_en_lat <= en_i | test_en_i;
  end

  assign clk_o = clk_i & r_en_lat;
endmodule

module clk_div_prog #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned RESET_DIV = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 test_mode_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 clk_o
);
  typedef enum logic [1:0] {RUN, WAIT_WRAP, GATE, SWITCH} state_t;

  state_t               r_state,    w_state_next;
  logic [DIV_WIDTH-1:0] r_div,      w_div_next;
  logic [DIV_WIDTH-1:0] r_cnt,      w_cnt_next;
  logic [DIV_WIDTH-1:0] r_div_pend, w_div_pend_next;
  logic                 r_clk_div,  w_clk_div_next;
  logic                 r_gate_en,  w_gate_en_next;
  logic                 r_gcnt,     w_gcnt_next;

  logic                 w_bypass;
  logic                 w_last_cnt;
  logic                 w_src_clk;
  logic                 w_gated_clk;

  assign w_bypass    = (r_div <= DIV_WIDTH'(1));
  assign w_last_cnt  = (r_cnt >= (r_div - DIV_WIDTH'(1)));
  assign div_ready_o = (r_state == RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= RUN;
      r_div      <= DIV_WIDTH'(RESET_DIV);
      r_cnt      <= '0;
      r_div_pend <= '0;
      r_clk_div  <= 1'b0;
      r_gate_en  <= 1'b1;
      r_gcnt     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_div      <= w_div_next;
      r_cnt      <= w_cnt_next;
      r_div_pend <= w_div_pend_next;
      r_clk_div  <= w_clk_div_next;
      r_gate_en  <= w_gate_en_next;
      r_gcnt     <= w_gcnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_div_next      = r_div;
    w_div_pend_next = r_div_pend;
    w_gate_en_next  = r_gate_en;
    w_gcnt_next     = r_gcnt;
    w_cnt_next      = '0;
    w_clk_div_next  = 1'b0;

    // Free-running counter; the divided clock is high for the first floor(d/2) counts.
    if (!w_bypass) begin
      w_cnt_next     = w_last_cnt ? '0 : r_cnt + DIV_WIDTH'(1);
      w_clk_div_next = (r_cnt < (r_div >> 1));
    end

    case (r_state)
      RUN: begin
        if (div_valid_i) begin
          w_div_pend_next = div_i;
          if (w_bypass) begin
            w_state_next   = GATE;
            w_gate_en_next = 1'b0;
            w_gcnt_next    = 1'b0;
          end else begin
            w_state_next   = WAIT_WRAP;
          end
        end
      end
      WAIT_WRAP: begin
        if (w_last_cnt) begin
          w_state_next   = GATE;
          w_gate_en_next = 1'b0;
          w_gcnt_next    = 1'b0;
        end
      end
      GATE: begin
        if (r_gcnt) w_state_next = SWITCH;
        else        w_gcnt_next  = 1'b1;
      end
      SWITCH: begin
        w_div_next     = r_div_pend;
        w_cnt_next     = '0;
        w_clk_div_next = 1'b0;
        w_gate_en_next = 1'b1;
        w_state_next   = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  clk_mux_cell u_src_mux (
    .clk0_i (r_clk_div),
    .clk1_i (clk_i),
    .sel_i  (w_bypass),
    .clk_o  (w_src_clk)
  );

  clk_gate_cell u_gate (
    .clk_i     (w_src_clk),
    .en_i      (en_i & r_gate_en),
    .test_en_i (test_mode_i),
    .clk_o     (w_gated_clk)
  );

  clk_mux_cell u_out_mux (
    .clk0_i (w_gated_clk),
    .clk1_i (clk_i),
    .sel_i  (test_mode_i),
    .clk_o  (clk_o)
  );
endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: expected clk_o/ready per clk_i cycle are
// queued by the stimulus and compared by an independent monitor.

module tb_clk_div_prog;
  localparam int DW = 8;

  logic          clk_i       = 1'b0;
  logic          rst_ni      = 1'b0;
  logic          en_i        = 1'b1;
  logic          test_mode_i = 1'b0;
  logic          div_valid_i = 1'b0;
  logic [DW-1:0] div_i       = '0;
  logic          div_ready_o;
  logic          clk_o;

  always #5 clk_i = ~clk_i;

  clk_div_prog #(.DIV_WIDTH(DW), .RESET_DIV(1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .test_mode_i (test_mode_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .clk_o       (clk_o)
  );

  // One entry per clk_i cycle: clk_o in the high and low phase of clk_i, and ready.
  typedef struct {
    logic  hi;
    logic  lo;
    logic  rdy;
    string name;
    int    idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Pattern chars: P = follows clk_i, H = high all cycle, L = low all cycle.
  task automatic expect_seq(input string name, input string clk_pat, input string rdy_pat);
    for (int i = 0; i < clk_pat.len(); i++) begin
      exp_t e;
      byte  c;
      c      = clk_pat[i];
      e.name = name;
      e.idx  = i + 1;
      e.hi   = (c == "P" || c == "H");
      e.lo   = (c == "H");
      e.rdy  = (rdy_pat[i] == "1");
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check_now(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin : mon_chk
        exp_t e;
        logic hi, lo, rdy;
        e   = exp_q.pop_front();
        hi  = clk_o;
        rdy = div_ready_o;
        @(negedge clk_i);
        #1;
        lo  = clk_o;
        n_cmp++;
        if (hi !== e.hi || lo !== e.lo || rdy !== e.rdy) begin
          n_err++;
          $display("FAIL %s[%0d] @%0t: got hi=%b lo=%b rdy=%b, expected hi=%b lo=%b rdy=%b",
                   e.name, e.idx, $time, hi, lo, rdy, e.hi, e.lo, e.rdy);
        end
      end
    end
  end

  int noise [7] = '{7, 9, 3, 6, 10, 11, 12};

  initial begin : stimulus
    tick();
    expect_seq("reset", "PP", "11");
    ticks(2);
    rst_ni = 1'b1;
    $display("reset released, factor 1");
    expect_seq("run_div1", "PP", "11");
    ticks(2);

    div_i = 8'd5; div_valid_i = 1'b1;
    $display("request div=5 from div=1");
    expect_seq("to_div5", "PLLLHHLLLHHLLL", "00011111111111");
    tick();
    div_valid_i = 1'b0;
    ticks(13);

    div_i = 8'd2; div_valid_i = 1'b1;
    $display("request div=2 from div=5, valid held with changing div_i");
    expect_seq("to_div2", "HHLLLLLLHLHLHL", "00000001111111");
    for (int i = 0; i < 7; i++) begin
      tick();
      div_i = DW'(noise[i]);
    end
    tick();
    div_valid_i = 1'b0; div_i = 8'd13;
    ticks(6);

    div_i = 8'd4; div_valid_i = 1'b1;
    $display("request div=4 from div=2");
    expect_seq("to_div4", "HLLLLHHLLHHLL", "0000111111111");
    tick();
    div_valid_i = 1'b0;
    ticks(12);

    en_i = 1'b0;
    $display("en_i low for 3 cycles at div=4");
    expect_seq("en_off", "LLLLHHLL", "11111111");
    ticks(3);
    en_i = 1'b1;
    ticks(5);

    test_mode_i = 1'b1; en_i = 1'b0;
    $display("test_mode_i high with en_i low");
    expect_seq("test_mode", "PPPPHHLL", "11111111");
    ticks(4);
    test_mode_i = 1'b0; en_i = 1'b1;
    ticks(4);

    div_i = 8'd4; div_valid_i = 1'b1;
    $display("request div=4 while already at div=4");
    expect_seq("same_div4", "HHLLLLLHHLL", "00000011111");
    tick();
    div_valid_i = 1'b0;
    ticks(10);

    div_i = 8'd8; div_valid_i = 1'b1;
    $display("request div=8, reset asserted in GATE");
    expect_seq("rst_in_gate", "HHLLPPPPPP", "0000111111");
    tick();
    div_valid_i = 1'b0;
    ticks(3);
    rst_ni = 1'b0;
    #1;
    check_now("rdy_async_reset", div_ready_o, 1'b1);
    ticks(2);
    rst_ni = 1'b1;
    ticks(4);

    tick();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
